reg_write_arbiter: RTL and testbench

Write-port controller for the 32×32 register file. After reset it sequences a clear of registers 1–31 through the single write port, overriding the file's non-zero reset pattern. It then shares that port among `NREQ` requesters (writeback, load unit, debug) using round-robin arbitration and a valid/ready handshake. It drives the register file's `w_en`/`w_addr`/`w_data` from registered outputs, so the file's negedge capture always sees signals that settled half a cycle earlier.

---
 rtl/reg_arb_pkg.sv | 12 +
 rtl/rr_picker.sv | 27 ++
 rtl/reg_write_arbiter.sv | 109 ++++++++++
 tb/tb_reg_write_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// Shared definitions for the register-file write-port arbiter.
package reg_arb_pkg;

    localparam int REG_AW = 5;
    localparam int NREG   = 1 << REG_AW;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request after index `last`, wrapping.
module rr_picker #(
    parameter int NREQ = 3,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx
);

    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && req[(int'(last) + k) % NREQ]) begin
                found                             = 1'b1;
                grant[(int'(last) + k) % NREQ]    = 1'b1;
                grant_idx                         = IW'((int'(last) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Register-file write-port controller: post-reset clear of x1..xN, then
// round-robin sharing of the single write port among NREQ requesters.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int              NREQ     = 3,
    parameter int              AW       = REG_AW,
    parameter int              DW       = 32,
    parameter bit              INIT_EN  = 1'b1,
    parameter logic [DW-1:0]   INIT_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 w_en,
    output logic [AW-1:0]        w_addr,
    output logic [DW-1:0]        w_data,
    output logic                 init_done
);

    localparam int IW = $clog2(NREQ);

    state_t          state, state_d;
    logic [AW-1:0]   cnt, cnt_d;
    logic [IW-1:0]   last, last_d;
    logic [NREQ-1:0] grant;
    logic [IW-1:0]   grant_idx;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;
    logic            xfer;
    logic            w_en_d;
    logic [AW-1:0]   w_addr_d;
    logic [DW-1:0]   w_data_d;
    logic            init_done_d;

    rr_picker #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_picker (
        .req       (req_valid),
        .last      (last),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Grants are withheld during the clear and while reset is asserted.
    assign req_ready = (state == ST_RUN && !rst) ? grant : '0;
    assign xfer      = |req_ready;
    assign sel_addr  = req_addr[int'(grant_idx)*AW +: AW];
    assign sel_data  = req_data[int'(grant_idx)*DW +: DW];

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        last_d      = last;
        w_en_d      = 1'b0;
        w_addr_d    = w_addr;
        w_data_d    = w_data;
        init_done_d = init_done;
        case (state)
            ST_INIT: begin
                w_en_d   = 1'b1;
                w_addr_d = cnt;
                w_data_d = INIT_VAL;
                cnt_d    = cnt + AW'(1);
                if (cnt == {AW{1'b1}}) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (xfer) begin
                    last_d = grant_idx;
                    // x0 is hardwired zero: accept the request but never write it.
                    if (sel_addr != '0) begin
                        w_en_d   = 1'b1;
                        w_addr_d = sel_addr;
                        w_data_d = sel_data;
                    end
                end
            end
            default: state_d = INIT_EN ? ST_INIT : ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT_EN ? ST_INIT : ST_RUN;
            cnt       <= AW'(1);
            last      <= IW'(NREQ - 1);
            w_en      <= 1'b0;
            w_addr    <= '0;
            w_data    <= '0;
            init_done <= !INIT_EN;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            last      <= last_d;
            w_en      <= w_en_d;
            w_addr    <= w_addr_d;
            w_data    <= w_data_d;
            init_done <= init_done_d;
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed table, corner sequences and random traffic.
module tb_reg_write_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*AW-1:0]  req_addr;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     req_ready;
    logic                w_en;
    logic [AW-1:0]       w_addr;
    logic [DW-1:0]       w_data;
    logic                init_done;

    logic [NREQ-1:0]     v0 = '0;
    logic [NREQ*AW-1:0]  a0 = '0;
    logic [NREQ*DW-1:0]  d0 = '0;
    logic [NREQ-1:0]     r0;
    logic                we0;
    logic [AW-1:0]       wa0;
    logic [DW-1:0]       wd0;
    logic                id0;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    reg_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .INIT_EN(1'b1), .INIT_VAL(32'h0)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .init_done(init_done)
    );

    reg_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .INIT_EN(1'b0), .INIT_VAL(32'h0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(v0), .req_addr(a0), .req_data(d0),
        .req_ready(r0), .w_en(we0), .w_addr(wa0), .w_data(wd0), .init_done(id0)
    );

    // Requester protocol: a pending request must hold valid/addr/data until its handshake.
    logic [NREQ-1:0]    pv = '0, phs = '0;
    logic [NREQ*AW-1:0] pa = '0;
    logic [NREQ*DW-1:0] pd = '0;
    logic               pr = 1'b1;
    always @(posedge clk) begin
        if (!rst && !pr) begin
            for (int i = 0; i < NREQ; i++) begin
                if (pv[i] && !phs[i])
                    assert (req_valid[i] && req_addr[i*AW +: AW] == pa[i*AW +: AW] &&
                            req_data[i*DW +: DW] == pd[i*DW +: DW])
                    else $error("FAIL req_stable requester %0d changed before handshake", i);
            end
        end
        pv  <= req_valid;
        phs <= req_valid & req_ready;
        pa  <= req_addr;
        pd  <= req_data;
        pr  <= rst;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural reference: clear phase counts 1..31, then round-robin service.
    bit              m_init;
    int              m_next;
    int              m_last;
    logic            m_en;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_data;
    logic            m_done;
    logic [NREQ-1:0] last_hs = '0;

    function automatic logic [NREQ-1:0] model_ready();
        if (rst || m_init) return '0;
        for (int k = 1; k <= NREQ; k++) begin
            int idx = (m_last + k) % NREQ;
            if (req_valid[idx]) return NREQ'(1 << idx);
        end
        return '0;
    endfunction

    task automatic model_edge();
        logic [NREQ-1:0] g;
        g = model_ready();
        if (rst) begin
            m_init = 1'b1; m_next = 1; m_last = NREQ - 1;
            m_en = 1'b0; m_addr = '0; m_data = '0; m_done = 1'b0;
        end else if (m_init) begin
            m_en = 1'b1; m_addr = AW'(m_next); m_data = '0;
            if (m_next == 31) begin
                m_init = 1'b0;
                m_done = 1'b1;
            end
            m_next++;
        end else begin
            m_en = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                if (g[i]) begin
                    m_last = i;
                    if (req_addr[i*AW +: AW] != '0) begin
                        m_en   = 1'b1;
                        m_addr = req_addr[i*AW +: AW];
                        m_data = req_data[i*DW +: DW];
                    end
                end
            end
        end
    endtask

    task automatic step();
        #1;
        chk("req_ready", req_ready, model_ready());
        last_hs = req_valid & req_ready;
        model_edge();
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("w_en", w_en, m_en);
        chk("w_addr", w_addr, m_addr);
        chk("w_data", w_data, m_data);
        chk("init_done", init_done, m_done);
    endtask

    typedef struct {
        logic [NREQ-1:0]    v;
        logic [NREQ*AW-1:0] a;
        logic [NREQ*DW-1:0] d;
        logic [NREQ-1:0]    rdy;
        logic               en;
        logic [AW-1:0]      wa;
        logic [DW-1:0]      wd;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] v, input int x0, input int x1, input int x2,
                                input logic [31:0] y0, input logic [31:0] y1, input logic [31:0] y2,
                                input logic [2:0] rdy, input logic en, input int wa, input logic [31:0] wd);
        vec_t r;
        r.v = v;
        r.a = {AW'(x2), AW'(x1), AW'(x0)};
        r.d = {y2, y1, y0};
        r.rdy = rdy;
        r.en = en;
        r.wa = AW'(wa);
        r.wd = wd;
        return r;
    endfunction

    localparam logic [31:0] DA = 32'hA0, DB = 32'hB1, DC = 32'hC2, DE = 32'hDEAD_BEEF;

    vec_t tbl[$];
    int   pulses;

    initial begin
        tbl.push_back(mk(3'b111, 3, 4, 5, DA, DB, DC, 3'b001, 1'b1, 3, DA));
        tbl.push_back(mk(3'b111, 3, 4, 5, DA, DB, DC, 3'b010, 1'b1, 4, DB));
        tbl.push_back(mk(3'b111, 3, 0, 5, DA, DE, DC, 3'b100, 1'b1, 5, DC));
        tbl.push_back(mk(3'b111, 3, 0, 5, DA, DE, DC, 3'b001, 1'b1, 3, DA));
        tbl.push_back(mk(3'b111, 3, 0, 5, DA, DE, DC, 3'b010, 1'b0, 3, DA));
        tbl.push_back(mk(3'b111, 3, 0, 5, DA, DE, DC, 3'b100, 1'b1, 5, DC));
        tbl.push_back(mk(3'b111, 3, 0, 5, DA, DE, DC, 3'b001, 1'b1, 3, DA));
        tbl.push_back(mk(3'b110, 3, 0, 5, DA, DE, DC, 3'b010, 1'b0, 3, DA));
        tbl.push_back(mk(3'b100, 3, 0, 5, DA, DE, DC, 3'b100, 1'b1, 5, DC));
        for (int k = 7; k <= 10; k++)
            tbl.push_back(mk(3'b100, 3, 0, k, DA, DE, 32'h1000 + k, 3'b100, 1'b1, k, 32'h1000 + k));
        tbl.push_back(mk(3'b000, 3, 0, 10, DA, DE, 32'h100A, 3'b000, 1'b0, 10, 32'h100A));

        // Reset with all three requesters already pending.
        rst       = 1'b1;
        req_valid = 3'b111;
        req_addr  = {5'd5, 5'd4, 5'd3};
        req_data  = {DC, DB, DA};
        step();
        step();
        chk("rst_w_en", w_en, 1'b0);
        chk("rst_init_done", init_done, 1'b0);
        chk("rst_ready", req_ready, 3'b000);

        rst = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            step();
            chk("clr_addr", w_addr, k);
            chk("clr_en", w_en, 1'b1);
            chk("clr_data", w_data, 32'h0);
            chk("clr_done", init_done, (k == 31));
            chk("clr_ready", req_ready, (k == 31) ? 3'b001 : 3'b000);
        end

        foreach (tbl[r]) begin
            req_valid = tbl[r].v;
            req_addr  = tbl[r].a;
            req_data  = tbl[r].d;
            #1;
            chk("tbl_ready", req_ready, tbl[r].rdy);
            step();
            chk("tbl_w_en", w_en, tbl[r].en);
            chk("tbl_w_addr", w_addr, tbl[r].wa);
            chk("tbl_w_data", w_data, tbl[r].wd);
        end

        // Reset part-way through the clear.
        req_valid = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) step();
        chk("mid_pre_addr", w_addr, 10);
        rst = 1'b1;
        step();
        chk("mid_rst_en", w_en, 1'b0);
        chk("mid_rst_addr", w_addr, 0);
        chk("mid_rst_data", w_data, 0);
        chk("mid_rst_done", init_done, 1'b0);
        rst = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 31; k++) begin
            step();
            chk("restart_addr", w_addr, k);
            if (w_en) pulses++;
        end
        chk("restart_writes", pulses, 31);
        step();
        chk("idle_w_en", w_en, 1'b0);

        // Random traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || last_hs[i]) begin
                    req_valid[i]         = ($urandom_range(0, 9) < 6);
                    req_addr[i*AW +: AW] = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom_range(1, 31));
                    req_data[i*DW +: DW] = $urandom;
                end
            end
            step();
        end

        // Instance without the clear: usable straight out of reset.
        req_valid = '0;
        rst = 1'b1;
        v0  = 3'b111;
        step();
        step();
        chk("noinit_rst_done", id0, 1'b1);
        chk("noinit_rst_ready", r0, 3'b000);
        chk("noinit_rst_w_en", we0, 1'b0);
        rst = 1'b0;
        v0  = 3'b010;
        a0[AW +: AW] = 5'd6;
        d0[DW +: DW] = 32'h66;
        #1;
        chk("noinit_ready", r0, 3'b010);
        chk("noinit_done", id0, 1'b1);
        step();
        chk("noinit_w_en", we0, 1'b1);
        chk("noinit_w_addr", wa0, 6);
        chk("noinit_w_data", wd0, 32'h66);
        v0 = '0;
        step();
        chk("noinit_idle", we0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
